// File: rtl/comb_sched_pkg.sv
// Shared types and constants for the HARQ combine user scheduler.
package comb_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARB  = 2'd1,
    S_RUN  = 2'd2
  } state_e;

  localparam int MAX_USERS   = 8;
  localparam int NCB_W_DEF   = 16;
  localparam int USER_IDX_W  = 4;

  localparam logic BUF_PING = 1'b0;
  localparam logic BUF_PONG = 1'b1;

endpackage

// File: rtl/rr_arbiter8.sv
// Combinational 8-way round-robin pick: first pending bit after rr_ptr_i.
module rr_arbiter8
  import comb_sched_pkg::*;
(
  input  logic [7:0]            pending_i,
  input  logic [2:0]            rr_ptr_i,
  output logic [USER_IDX_W-1:0] winner_o,
  output logic                  valid_o
);

  logic [2:0] idx;

  // Scan from farthest to nearest so the nearest candidate after rr_ptr_i wins.
  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    idx      = '0;
    for (int i = 8; i >= 1; i--) begin
      idx = rr_ptr_i + 3'(i);
      if (pending_i[idx]) begin
        winner_o = USER_IDX_W'(idx);
        valid_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/combine_user_scheduler.sv
// Round-robin scheduler of per-user HARQ combine jobs onto one combiner,
// with ping/pong output-buffer occupancy tracking and a RUN watchdog.
module combine_user_scheduler
  import comb_sched_pkg::*;
#(
  parameter int NUM_USERS      = MAX_USERS,
  parameter int NCB_W          = NCB_W_DEF,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                       i_core_clk,
  input  logic                       i_rx_rst,
  input  logic [NUM_USERS-1:0]       i_user_req,
  input  logic [NUM_USERS*NCB_W-1:0] i_users_ncb,
  input  logic                       i_combine_done,
  input  logic [1:0]                 i_sendharq_done,
  output logic                       o_Combine_process_request,
  output logic [USER_IDX_W-1:0]      o_Combine_user_index,
  output logic [NCB_W-1:0]           o_Combine_ncb,
  output logic                       o_buf_sel,
  output logic [1:0]                 o_buf_full,
  output logic                       o_skip_pulse,
  output logic                       o_timeout_err,
  output logic                       o_busy
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e                  state_q;
  logic [NUM_USERS-1:0]    pend_q, pend_d, grant_mask;
  logic [2:0]              rr_ptr_q;
  logic [1:0]              buf_full_q, buf_full_d, buf_set;
  logic                    wr_ptr_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [USER_IDX_W-1:0]   win;
  logic                    win_vld;
  logic [NCB_W-1:0]        ncb_sel;

  rr_arbiter8 u_arb (
    .pending_i (pend_q),
    .rr_ptr_i  (rr_ptr_q),
    .winner_o  (win),
    .valid_o   (win_vld)
  );

  // Pending and buffer-occupancy next state; new requests and fills win over clears.
  always_comb begin
    grant_mask = '0;
    buf_set    = '0;
    ncb_sel    = i_users_ncb[int'(win[2:0])*NCB_W +: NCB_W];
    if (state_q == S_ARB && win_vld) grant_mask[win[2:0]] = 1'b1;
    if (state_q == S_RUN && i_combine_done) buf_set[wr_ptr_q] = 1'b1;
    pend_d     = (pend_q & ~grant_mask) | i_user_req;
    buf_full_d = (buf_full_q & ~i_sendharq_done) | buf_set;
  end

  // Scheduler FSM with registered combiner-facing outputs.
  always_ff @(posedge i_core_clk) begin
    if (i_rx_rst) begin
      state_q                   <= S_IDLE;
      pend_q                    <= '0;
      rr_ptr_q                  <= 3'd7;
      buf_full_q                <= '0;
      wr_ptr_q                  <= BUF_PING;
      cnt_q                     <= '0;
      o_Combine_process_request <= 1'b0;
      o_Combine_user_index      <= '0;
      o_Combine_ncb             <= '0;
      o_buf_sel                 <= BUF_PING;
      o_skip_pulse              <= 1'b0;
      o_timeout_err             <= 1'b0;
    end else begin
      pend_q        <= pend_d;
      buf_full_q    <= buf_full_d;
      o_skip_pulse  <= 1'b0;
      o_timeout_err <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (|pend_q && !buf_full_q[wr_ptr_q]) state_q <= S_ARB;
        end
        S_ARB: begin
          if (win_vld) begin
            o_Combine_user_index <= win;
            o_Combine_ncb        <= ncb_sel;
            rr_ptr_q             <= win[2:0];
            if (ncb_sel == '0) begin
              o_skip_pulse <= 1'b1;
              state_q      <= S_IDLE;
            end else begin
              o_Combine_process_request <= 1'b1;
              o_buf_sel                 <= wr_ptr_q;
              cnt_q                     <= '0;
              state_q                   <= S_RUN;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          if (i_combine_done) begin
            o_Combine_process_request <= 1'b0;
            wr_ptr_q                  <= ~wr_ptr_q;
            state_q                   <= S_IDLE;
          end else if (cnt_q == CNT_LAST) begin
            o_Combine_process_request <= 1'b0;
            o_timeout_err             <= 1'b1;
            state_q                   <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_buf_full = buf_full_q;
  assign o_busy     = (state_q != S_IDLE) | (|pend_q);

  // A buffer cannot be refilled and drained on the same edge.
  a_no_fill_drain_clash: assert property (
    @(posedge i_core_clk) disable iff (i_rx_rst) !(|(buf_set & i_sendharq_done)));

endmodule

// File: tb/tb_combine_user_scheduler.sv
// Directed bench for combine_user_scheduler: vector table plus hand sequences.
module tb_combine_user_scheduler;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   user_req;
  logic [127:0] users_ncb;
  logic         done;
  logic [1:0]   shq;
  logic         o_req;
  logic [3:0]   o_idx;
  logic [15:0]  o_ncb;
  logic         o_bsel;
  logic [1:0]   o_bfull;
  logic         o_skip;
  logic         o_tmo;
  logic         o_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  combine_user_scheduler #(.TIMEOUT_CYCLES(16)) dut (
    .i_core_clk                (clk),
    .i_rx_rst                  (rst),
    .i_user_req                (user_req),
    .i_users_ncb               (users_ncb),
    .i_combine_done            (done),
    .i_sendharq_done           (shq),
    .o_Combine_process_request (o_req),
    .o_Combine_user_index      (o_idx),
    .o_Combine_ncb             (o_ncb),
    .o_buf_sel                 (o_bsel),
    .o_buf_full                (o_bfull),
    .o_skip_pulse              (o_skip),
    .o_timeout_err             (o_tmo),
    .o_busy                    (o_busy)
  );

  typedef struct {
    logic        rst;
    logic [7:0]  req;
    logic        done;
    logic [1:0]  shq;
    logic        e_req;
    logic [3:0]  e_idx;
    logic [15:0] e_ncb;
    logic        e_bsel;
    logic [1:0]  e_bfull;
    logic        e_skip;
    logic        e_busy;
  } vec_t;

  vec_t tbl [22];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_ncb(input int u, input logic [15:0] v);
    users_ncb[u*16 +: 16] = v;
  endtask

  task automatic do_reset();
    rst = 1'b1; user_req = '0; done = 1'b0; shq = '0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; user_req = '0; done = 1'b0; shq = '0; users_ncb = '0;
    set_ncb(0, 16'd50);  set_ncb(1, 16'd100); set_ncb(2, 16'd200); set_ncb(3, 16'd300);
    set_ncb(4, 16'd400); set_ncb(5, 16'd500); set_ncb(6, 16'd600); set_ncb(7, 16'd700);

    // rst req done shq | req idx ncb bsel bfull skip busy
    tbl[0]  = '{1'b1, 8'h00, 1'b0, 2'b00, 1'b0, 4'd0, 16'd0,   1'b0, 2'b00, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 8'h02, 1'b0, 2'b00, 1'b0, 4'd0, 16'd0,   1'b0, 2'b00, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 4'd0, 16'd0,   1'b0, 2'b00, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 8'h00, 1'b0, 2'b00, 1'b1, 4'd1, 16'd100, 1'b0, 2'b00, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 2'b00, 1'b1, 4'd1, 16'd100, 1'b0, 2'b00, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 8'h00, 1'b1, 2'b00, 1'b0, 4'd1, 16'd100, 1'b0, 2'b01, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 2'b01, 1'b0, 4'd1, 16'd100, 1'b0, 2'b00, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 8'h00, 1'b0, 2'b00, 1'b0, 4'd0, 16'd0,   1'b0, 2'b00, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 8'h70, 1'b0, 2'b00, 1'b0, 4'd0, 16'd0,   1'b0, 2'b00, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 4'd0, 16'd0,   1'b0, 2'b00, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 2'b00, 1'b1, 4'd4, 16'd400, 1'b0, 2'b00, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 2'b00, 1'b0, 4'd4, 16'd400, 1'b0, 2'b01, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 4'd4, 16'd400, 1'b0, 2'b01, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 2'b00, 1'b1, 4'd5, 16'd500, 1'b1, 2'b01, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 8'h00, 1'b1, 2'b00, 1'b0, 4'd5, 16'd500, 1'b1, 2'b11, 1'b0, 1'b1};
    tbl[15] = '{1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 4'd5, 16'd500, 1'b1, 2'b11, 1'b0, 1'b1};
    tbl[16] = '{1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 4'd5, 16'd500, 1'b1, 2'b11, 1'b0, 1'b1};
    tbl[17] = '{1'b0, 8'h00, 1'b0, 2'b01, 1'b0, 4'd5, 16'd500, 1'b1, 2'b10, 1'b0, 1'b1};
    tbl[18] = '{1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 4'd5, 16'd500, 1'b1, 2'b10, 1'b0, 1'b1};
    tbl[19] = '{1'b0, 8'h00, 1'b0, 2'b00, 1'b1, 4'd6, 16'd600, 1'b0, 2'b10, 1'b0, 1'b1};
    tbl[20] = '{1'b0, 8'h00, 1'b1, 2'b00, 1'b0, 4'd6, 16'd600, 1'b0, 2'b11, 1'b0, 1'b0};
    tbl[21] = '{1'b0, 8'h00, 1'b0, 2'b11, 1'b0, 4'd6, 16'd600, 1'b0, 2'b00, 1'b0, 1'b0};

    for (int i = 0; i < 22; i++) begin
      rst = tbl[i].rst; user_req = tbl[i].req; done = tbl[i].done; shq = tbl[i].shq;
      step();
      check($sformatf("row%0d_req", i),   32'(o_req),   32'(tbl[i].e_req));
      check($sformatf("row%0d_idx", i),   32'(o_idx),   32'(tbl[i].e_idx));
      check($sformatf("row%0d_ncb", i),   32'(o_ncb),   32'(tbl[i].e_ncb));
      check($sformatf("row%0d_bsel", i),  32'(o_bsel),  32'(tbl[i].e_bsel));
      check($sformatf("row%0d_bfull", i), 32'(o_bfull), 32'(tbl[i].e_bfull));
      check($sformatf("row%0d_skip", i),  32'(o_skip),  32'(tbl[i].e_skip));
      check($sformatf("row%0d_tmo", i),   32'(o_tmo),   32'h0);
      check($sformatf("row%0d_busy", i),  32'(o_busy),  32'(tbl[i].e_busy));
    end
    rst = 1'b0; user_req = '0; done = 1'b0; shq = '0;

    // All eight users at once: grant order 0..7, ping/pong alternation.
    do_reset();
    user_req = 8'hFF; step(); user_req = '0;
    for (int k = 0; k < 8; k++) begin
      n = 0;
      while (!o_req && n < 8) begin step(); n++; end
      check($sformatf("ff_grant%0d_req", k), 32'(o_req), 32'h1);
      check($sformatf("ff_grant%0d_idx", k), 32'(o_idx), 32'(k));
      check($sformatf("ff_grant%0d_bsel", k), 32'(o_bsel), 32'(k % 2));
      check($sformatf("ff_grant%0d_ncb", k), 32'(o_ncb), 32'((k == 0) ? 50 : 100 * k));
      done = 1'b1; step(); done = 1'b0;
      check($sformatf("ff_fill%0d", k), 32'(o_bfull), (k % 2 == 1) ? 32'h2 : 32'h1);
      shq = o_bfull; step(); shq = '0;
      check($sformatf("ff_drain%0d", k), 32'(o_bfull), 32'h0);
    end
    check("ff_idle_busy", 32'(o_busy), 32'h0);

    // Zero-Ncb user is skipped; the next user is served normally.
    set_ncb(3, 16'd0);
    do_reset();
    user_req = 8'h28; step(); user_req = '0;
    step(); step();
    check("skip_pulse", 32'(o_skip), 32'h1);
    check("skip_req", 32'(o_req), 32'h0);
    check("skip_idx", 32'(o_idx), 32'h3);
    check("skip_bfull", 32'(o_bfull), 32'h0);
    step();
    check("skip_pulse_one_cycle", 32'(o_skip), 32'h0);
    step();
    check("after_skip_req", 32'(o_req), 32'h1);
    check("after_skip_idx", 32'(o_idx), 32'h5);
    check("after_skip_ncb", 32'(o_ncb), 32'd500);
    check("after_skip_bsel", 32'(o_bsel), 32'h0);
    done = 1'b1; step(); done = 1'b0;
    check("after_skip_bfull", 32'(o_bfull), 32'h1);
    shq = 2'b01; step(); shq = '0;
    set_ncb(3, 16'd300);

    // Watchdog: no done, request drops after 16 RUN cycles.
    do_reset();
    user_req = 8'h04; step(); user_req = '0;
    step(); step();
    check("tmo_start_req", 32'(o_req), 32'h1);
    n = 0;
    while (o_req && n < 40) begin step(); n++; end
    check("tmo_run_cycles", 32'(n), 32'd16);
    check("tmo_pulse", 32'(o_tmo), 32'h1);
    check("tmo_bfull", 32'(o_bfull), 32'h0);
    step();
    check("tmo_pulse_one_cycle", 32'(o_tmo), 32'h0);
    user_req = 8'h80; step(); user_req = '0;
    step(); step();
    check("tmo_next_idx", 32'(o_idx), 32'h7);
    check("tmo_next_bsel", 32'(o_bsel), 32'h0);
    done = 1'b1; step(); done = 1'b0;
    shq = 2'b01; step(); shq = '0;

    // Reset during RUN with other users pending.
    do_reset();
    user_req = 8'h02; step(); user_req = '0;
    step(); step();
    check("mid_rst_run_req", 32'(o_req), 32'h1);
    user_req = 8'h0C; step(); user_req = '0;
    rst = 1'b1; step(); rst = 1'b0;
    check("mid_rst_req", 32'(o_req), 32'h0);
    check("mid_rst_idx", 32'(o_idx), 32'h0);
    check("mid_rst_ncb", 32'(o_ncb), 32'h0);
    check("mid_rst_busy", 32'(o_busy), 32'h0);
    check("mid_rst_bfull", 32'(o_bfull), 32'h0);
    step();
    check("mid_rst_stays_idle", 32'(o_busy), 32'h0);
    user_req = 8'h04; step(); user_req = '0;
    step();
    check("rereq_not_yet", 32'(o_req), 32'h0);
    step();
    check("rereq_req", 32'(o_req), 32'h1);
    check("rereq_idx", 32'(o_idx), 32'h2);
    check("rereq_ncb", 32'(o_ncb), 32'd200);
    check("rereq_bsel", 32'(o_bsel), 32'h0);
    done = 1'b1; step(); done = 1'b0;
    check("rereq_bfull", 32'(o_bfull), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/combine_user_scheduler.md
Name: combine_user_scheduler

Overview:
Sequences HARQ combine jobs for up to 8 users onto the single FSM_Combine datapath. Collects per-user combine requests and arbitrates them round-robin. Tracks occupancy of the COMB ping/pong buffers, drives the combiner's process-request, user-index and buffer-select, and frees buffers when SENDHARQ drain completes. Sits between the rx control layer and FSM_Combine.

Parameters:
NUM_USERS, 8, number of requesters (index width 4 bits fixed)
NCB_W, 16, width of each per-user Ncb field
TIMEOUT_CYCLES, 4096, max cycles in RUN without combine completion before abort

Ports:
i_core_clk  in  1  core clock
i_rx_rst  in  1  reset; one clock; reset is synchronous and active-high
i_user_req  in  8  one-cycle pulse per user: combine job pending
i_users_ncb  in  128  8 x NCB_W Ncb values, user u at bits [16u+15:16u]
i_combine_done  in  1  pulse from combiner: RDM data for current job complete
i_sendharq_done  in  2  pulse per buffer (bit0 ping, bit1 pong): buffer drained
o_Combine_process_request  out  1  job active to combiner
o_Combine_user_index  out  4  granted user
o_Combine_ncb  out  16  Ncb of granted user
o_buf_sel  out  1  buffer written by current job (0 ping, 1 pong)
o_buf_full  out  2  buffer holds combined data awaiting SENDHARQ
o_skip_pulse  out  1  granted user had Ncb==0, job dropped
o_timeout_err  out  1  pulse: job aborted on timeout
o_busy  out  1  state != IDLE or any pending

Behaviour:
- Reset (i_rx_rst high at edge): state IDLE, pending=0, rr_ptr=7, buf_full=0, wr_ptr=0, timeout counter=0, all outputs 0.
- pending[u] set on edge where i_user_req[u]=1. Cleared at the ARB edge that grants u. Same-cycle set and grant of u: set wins, so u stays pending.
- Free buffer: buf_full[wr_ptr]==0. Only wr_ptr is considered; the send side drains in order.
- States: IDLE, ARB, RUN.
- IDLE -> ARB when |pending and free buffer; else stay.
- ARB (1 cycle): winner = first set pending bit searching rr_ptr+1 .. rr_ptr+8 mod 8. Register index and that user's Ncb; rr_ptr <= winner; clear pending[winner].
  - If Ncb==0: o_skip_pulse=1 for one cycle, return to IDLE, no buffer change.
  - Else: -> RUN, o_Combine_process_request<=1, o_buf_sel<=wr_ptr.
- Latency: i_user_req sampled at edge 0 -> pending edge 1 -> ARB edge 2 -> request high after edge 3.
- RUN: request, index, ncb and buf_sel held stable. Counter increments each cycle.
  - On i_combine_done: request<=0, buf_full[wr_ptr]<=1, wr_ptr toggles, -> IDLE.
  - If counter reaches TIMEOUT_CYCLES-1 without done: request<=0, o_timeout_err pulse, buffer not marked, wr_ptr unchanged, -> IDLE.
  - i_combine_done outside RUN is ignored.
- i_sendharq_done[b] clears buf_full[b]. If the same edge both sets and clears the same bit, set wins (clear was for the previous fill; cannot legally coincide, so assert in sim).
- Both buffers full: IDLE holds, pending accumulates, no grant until a free.
- Synchronous reset mid-RUN: request drops at that edge, pending and buffer state lost.
- o_busy = (state!=IDLE) | (|pending).

Decomposition:
- Package comb_sched_pkg: state enum (IDLE, ARB, RUN), NUM_USERS, NCB_W, user index width, ping/pong encodings.
- Sub-module rr_arbiter8: combinational 8-bit round-robin pick. Inputs are pending and rr_ptr; outputs are winner index and valid. Instantiated once.

Test Plan:
- Single request user 1, Ncb=100 -> request high after 3rd edge with index 1, ncb 100, buf_sel 0. Done pulse -> buf_full=01, request low next edge.
- i_user_req=8'hFF in one cycle, done after each job, sendharq_done after each fill -> grant order 0,1,...,7. buf_sel alternates 0,1,0,...
- Three jobs with no sendharq_done -> two complete (buf_full=11), third held with o_busy=1. sendharq_done=01 -> third granted with buf_sel 0.
- User 3 Ncb=0 requested -> o_skip_pulse one cycle, no request, buffers unchanged. Next user granted normally.
- Request with no done, TIMEOUT_CYCLES=16 -> request drops after 16 RUN cycles, o_timeout_err pulse, buf_full unchanged, wr_ptr unchanged.
- i_rx_rst asserted during RUN with pending=8'h0C -> next edge all outputs 0, pending 0. Re-request user 2 -> normal 3-edge latency.
